pool_stride_out: RTL

POOL_STRIDE_OUT -- requirements
Module: pool_stride_out

---
 rtl/pool_pkg.sv | 10 +
 rtl/pool_out_fifo.sv | 39 +++
 rtl/pool_stride_out.sv | 90 +++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// pool_pkg: shared widths, FIFO depth default and output FIFO entry layout.
package pool_pkg;
  localparam int POOL_DATA_W = 16;
  localparam int POOL_CNT_W = 16;
  localparam int POOL_DEPTH = 8;
  typedef struct packed {
    logic [POOL_DATA_W-1:0] data;
    logic last;
  } pool_entry_t;
endpackage

// File: rtl/pool_out_fifo.sv
// pool_out_fifo: first-word-fall-through FIFO; ports clk/rst, push/din, pop/dout, full/empty.
module pool_out_fifo
  import pool_pkg::*;
#(
  parameter int W = $bits(pool_entry_t),
  parameter int DEPTH = POOL_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  logic do_pop, do_push;
  // extra pointer bit tells full from empty when the low bits match
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem[rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/pool_stride_out.sv
// pool_stride_out: stride-2 decimation, optional ReLU and frame control feeding a FWFT output FIFO; ports clk/rst, start/row_length/num_rows/relu_en, in_valid/in_data, out_valid/out_ready/out_data/out_last, busy/done/overflow.
module pool_stride_out
  import pool_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int CNT_W = POOL_CNT_W,
  parameter int DEPTH = POOL_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  row_length,
  input  logic [CNT_W-1:0]  num_rows,
  input  logic              relu_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic last;
  } entry_t;
  logic [CNT_W-1:0] rl, nr, col, row, re, ne;
  logic relu, deg, fin, go, accept, kept, is_last, pop, full, empty;
  entry_t din, dout;
  assign re = {rl[CNT_W-1:1], 1'b0};
  assign ne = {nr[CNT_W-1:1], 1'b0};
  assign go = start & ~busy;
  // fin blocks input after the final kept sample; deg marks a frame too small to produce output
  assign accept = busy & in_valid & ~fin & ~deg;
  assign kept = accept & col[0] & row[0] & (col < re);
  assign is_last = kept & (row == ne - 1'b1) & (col == re - 1'b1);
  assign pop = out_valid & out_ready;
  assign din = '{data: (relu & in_data[DATA_W-1]) ? '0 : in_data, last: is_last};
  assign out_valid = ~empty;
  assign out_data = dout.data;
  assign out_last = dout.last;
  pool_out_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(kept),
    .din(din),
    .pop(pop),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
      col <= '0;
      row <= '0;
      rl <= '0;
      nr <= '0;
      relu <= 1'b0;
      deg <= 1'b0;
      fin <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        rl <= row_length;
        nr <= num_rows;
        relu <= relu_en;
        col <= '0;
        row <= '0;
        overflow <= 1'b0;
        fin <= 1'b0;
        deg <= (row_length < CNT_W'(2)) | (num_rows < CNT_W'(2));
        busy <= 1'b1;
      end else if (busy & (deg | (pop & out_last))) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (accept) begin
        col <= (col == rl - 1'b1) ? '0 : col + 1'b1;
        if (col == rl - 1'b1) row <= row + 1'b1;
      end
      if (is_last) fin <= 1'b1;
      if (kept & full & ~pop) overflow <= 1'b1;
    end
  end
endmodule
